// File: rtl/sram_byte_reader_if.sv
// Bundle between the byte reader, the tile SRAM read port and the byte consumer.
// The slave side is the reader; the master side drives commands, SRAM data and out_ready.
interface sram_byte_reader_if #(
  parameter int ADDR_W = 10
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_words;
  logic              sram_rd_en;
  logic [ADDR_W-1:0] sram_addr;
  logic [127:0]      sram_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;
  logic [3:0]        out_offset;
  logic              out_last;
  logic              busy;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_words, sram_rdata, out_ready,
    output cmd_ready, sram_rd_en, sram_addr, out_valid, out_data, out_offset, out_last, busy
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_words, sram_rdata, out_ready,
    input  cmd_ready, sram_rd_en, sram_addr, out_valid, out_data, out_offset, out_last, busy
  );
endinterface

// File: rtl/sram_byte_reader.sv
// Fetches 128-bit tile SRAM words and streams their bytes in position-offset order,
// undoing the offset-to-lane scatter applied by the tile write path.
module sram_byte_reader #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input logic               clk,
  input logic               rst_n,
  sram_byte_reader_if.slave io_bus
);
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_STREAM} state_t;

  localparam logic [1:0]        WAIT_LAST = 2'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] ZERO_W    = {ADDR_W{1'b0}};

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_remain;
  logic [1:0]        r_wait_cnt;
  logic [127:0]      r_word;
  logic              r_rd_en;
  logic              r_out_valid;
  logic [7:0]        r_out_data;
  logic [3:0]        r_out_offset;
  logic              r_out_last;
  logic              r_busy;
  logic              w_accept;
  logic              w_hs;
  logic              w_word_done;
  logic              w_wait_done;

  // Same offset-to-lane mapping the write path uses for its bytemasks.
  function automatic logic [3:0] lane_of(input logic [3:0] off);
    case (off)
      4'd0:    lane_of = 4'd15;
      4'd1:    lane_of = 4'd11;
      4'd2:    lane_of = 4'd14;
      4'd3:    lane_of = 4'd10;
      4'd4:    lane_of = 4'd7;
      4'd5:    lane_of = 4'd3;
      4'd6:    lane_of = 4'd6;
      4'd7:    lane_of = 4'd2;
      4'd8:    lane_of = 4'd13;
      4'd9:    lane_of = 4'd9;
      4'd10:   lane_of = 4'd12;
      4'd11:   lane_of = 4'd8;
      4'd12:   lane_of = 4'd5;
      4'd13:   lane_of = 4'd1;
      4'd14:   lane_of = 4'd4;
      4'd15:   lane_of = 4'd0;
      default: lane_of = 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] pick_byte(input logic [127:0] word, input logic [3:0] off);
    pick_byte = word[{lane_of(off), 3'b000} +: 8];
  endfunction

  // Handshake and phase-completion decodes.
  always_comb begin
    w_accept    = (r_state == S_IDLE) && io_bus.cmd_valid;
    w_hs        = (r_state == S_STREAM) && r_out_valid && io_bus.out_ready;
    w_word_done = w_hs && (r_out_offset == 4'd15);
    w_wait_done = (r_state == S_WAIT) && (r_wait_cnt == WAIT_LAST);
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = S_READ;
        else          w_state_next = S_IDLE;
      end
      S_READ: w_state_next = S_WAIT;
      S_WAIT: begin
        if (w_wait_done) w_state_next = S_STREAM;
        else             w_state_next = S_WAIT;
      end
      S_STREAM: begin
        if (w_word_done) begin
          if (r_remain != ZERO_W) w_state_next = S_READ;
          else                    w_state_next = S_IDLE;
        end else begin
          w_state_next = S_STREAM;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst_n) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Address/count bookkeeping, word capture and registered outputs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_addr       <= ZERO_W;
      r_remain     <= ZERO_W;
      r_wait_cnt   <= 2'd0;
      r_word       <= 128'd0;
      r_rd_en      <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= 8'd0;
      r_out_offset <= 4'd0;
      r_out_last   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_rd_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr   <= io_bus.cmd_addr;
            r_remain <= io_bus.cmd_words;
            r_rd_en  <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        S_READ: r_wait_cnt <= 2'd0;
        S_WAIT: begin
          if (w_wait_done) begin
            r_word       <= io_bus.sram_rdata;
            r_out_valid  <= 1'b1;
            r_out_offset <= 4'd0;
            r_out_data   <= pick_byte(io_bus.sram_rdata, 4'd0);
            r_out_last   <= 1'b0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 2'd1;
          end
        end
        S_STREAM: begin
          if (w_word_done) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (r_remain != ZERO_W) begin
              r_remain <= r_remain - ADDR_W'(1);
              r_addr   <= r_addr + ADDR_W'(1);
              r_rd_en  <= 1'b1;
            end else begin
              r_busy <= 1'b0;
            end
          end else if (w_hs) begin
            r_out_offset <= r_out_offset + 4'd1;
            r_out_data   <= pick_byte(r_word, r_out_offset + 4'd1);
            r_out_last   <= (r_remain == ZERO_W) && (r_out_offset == 4'd14);
          end
        end
        default: ;
      endcase
    end
  end

  assign io_bus.cmd_ready  = (r_state == S_IDLE);
  assign io_bus.sram_rd_en = r_rd_en;
  assign io_bus.sram_addr  = r_addr;
  assign io_bus.out_valid  = r_out_valid;
  assign io_bus.out_data   = r_out_data;
  assign io_bus.out_offset = r_out_offset;
  assign io_bus.out_last   = r_out_last;
  assign io_bus.busy       = r_busy;
endmodule

// File: tb/tb_sram_byte_reader.sv
// Directed bench for sram_byte_reader: one reader with RD_LAT=1 and one with RD_LAT=3,
// each fed by a small SRAM model that drives random data outside the valid read cycle.
module tb_sram_byte_reader;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] lane_tab [16] = '{4'd15, 4'd11, 4'd14, 4'd10, 4'd7, 4'd3, 4'd6, 4'd2,
                                4'd13, 4'd9, 4'd12, 4'd8, 4'd5, 4'd1, 4'd4, 4'd0};
  logic       ready_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  sram_byte_reader_if #(.ADDR_W(10)) ifa ();
  sram_byte_reader_if #(.ADDR_W(10)) ifb ();

  sram_byte_reader #(.ADDR_W(10), .RD_LAT(1)) dut_a (.clk(clk), .rst_n(rst_n), .io_bus(ifa.slave));
  sram_byte_reader #(.ADDR_W(10), .RD_LAT(3)) dut_b (.clk(clk), .rst_n(rst_n), .io_bus(ifb.slave));

  // Word at address a: lane k holds {a[3:0]^5, k}, so address 5 holds value k in lane k.
  function automatic logic [127:0] mem_word(input logic [9:0] a);
    logic [127:0] w;
    w = 128'd0;
    for (int k = 0; k < 16; k++) w[8*k +: 8] = {a[3:0] ^ 4'h5, 4'(k)};
    return w;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [9:0] a, input int off);
    return {a[3:0] ^ 4'h5, lane_tab[off]};
  endfunction

  // SRAM models: valid data only in cycle R+RD_LAT, random garbage in every other cycle.
  logic       b_v1 = 1'b0, b_v2 = 1'b0;
  logic [9:0] b_a1 = 10'd0, b_a2 = 10'd0;
  always @(posedge clk) begin
    ifa.sram_rdata <= ifa.sram_rd_en ? mem_word(ifa.sram_addr)
                                     : {$urandom(), $urandom(), $urandom(), $urandom()};
    b_v1 <= ifb.sram_rd_en;
    b_a1 <= ifb.sram_addr;
    b_v2 <= b_v1;
    b_a2 <= b_a1;
    ifb.sram_rdata <= b_v2 ? mem_word(b_a2)
                           : {$urandom(), $urandom(), $urandom(), $urandom()};
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    tick;
    tick;
    checks++; if (ifa.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", ifa.cmd_ready); end
    checks++; if ({ifa.sram_rd_en, ifa.out_valid, ifa.out_last, ifa.busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000", {ifa.sram_rd_en, ifa.out_valid, ifa.out_last, ifa.busy}); end
    checks++; if (ifa.sram_addr !== 10'd0) begin errors++; $display("FAIL reset_addr got=%h exp=0", ifa.sram_addr); end
    checks++; if ({ifa.out_data, ifa.out_offset} !== 12'd0) begin
      errors++; $display("FAIL reset_data got=%h exp=0", {ifa.out_data, ifa.out_offset}); end
    checks++; if ({ifb.cmd_ready, ifb.busy, ifb.out_valid, ifb.sram_rd_en} !== 4'b1000) begin
      errors++; $display("FAIL reset_b got=%b exp=1000", {ifb.cmd_ready, ifb.busy, ifb.out_valid, ifb.sram_rd_en}); end
    rst_n = 1'b0;
    tick;
    checks++; if ({ifa.cmd_ready, ifa.busy} !== 2'b10) begin errors++; $display("FAIL post_reset_idle got=%b exp=10", {ifa.cmd_ready, ifa.busy}); end
  endtask

  task automatic test_lane_order;
    int n = 0, cyc = 0;
    ifa.out_ready = 1'b1;
    ifa.cmd_addr  = 10'd5;
    ifa.cmd_words = 10'd0;
    ifa.cmd_valid = 1'b1;
    checks++; if (ifa.cmd_ready !== 1'b1) begin errors++; $display("FAIL lane_cmd_ready got=%b exp=1", ifa.cmd_ready); end
    tick;
    ifa.cmd_valid = 1'b0;
    checks++; if ({ifa.sram_rd_en, ifa.sram_addr, ifa.cmd_ready, ifa.busy} !== {1'b1, 10'd5, 1'b0, 1'b1}) begin
      errors++; $display("FAIL lane_read got rd=%b addr=%0d rdy=%b busy=%b exp rd=1 addr=5 rdy=0 busy=1",
                         ifa.sram_rd_en, ifa.sram_addr, ifa.cmd_ready, ifa.busy); end
    while (n < 16 && cyc < 40) begin
      if (ifa.out_valid === 1'b1) begin
        if (n == 0) begin
          checks++; if (cyc != 2) begin errors++; $display("FAIL lane_latency got=%0d exp=2", cyc); end
        end
        checks++;
        if ({ifa.out_data, ifa.out_offset, ifa.out_last} !== {exp_byte(10'd5, n), 4'(n), n == 15}) begin
          errors++; $display("FAIL lane_byte n=%0d got data=%0d off=%0d last=%b exp data=%0d off=%0d last=%b",
                             n, ifa.out_data, ifa.out_offset, ifa.out_last, exp_byte(10'd5, n), n, n == 15);
        end
        n++;
      end
      tick;
      cyc++;
    end
    checks++; if (n != 16) begin errors++; $display("FAIL lane_count got=%0d exp=16", n); end
    checks++; if ({ifa.cmd_ready, ifa.out_valid, ifa.busy} !== 3'b100) begin
      errors++; $display("FAIL lane_done got=%b exp=100", {ifa.cmd_ready, ifa.out_valid, ifa.busy}); end
  endtask

  task automatic test_backpressure;
    int n = 0, cyc = 0;
    logic hold = 1'b0;
    logic [12:0] held = 13'd0;
    ifa.cmd_addr  = 10'd5;
    ifa.cmd_words = 10'd0;
    ifa.cmd_valid = 1'b1;
    tick;
    ifa.cmd_valid = 1'b0;
    while (n < 16 && cyc < 200) begin
      ifa.out_ready = ready_pat[cyc % 4];
      if (hold) begin
        checks++;
        if ({ifa.out_valid, ifa.out_data, ifa.out_offset, ifa.out_last} !== {1'b1, held}) begin
          errors++; $display("FAIL bp_hold got=%h exp=%h", {ifa.out_valid, ifa.out_data, ifa.out_offset, ifa.out_last}, {1'b1, held});
        end
      end
      if (ifa.out_valid === 1'b1 && ifa.out_ready) begin
        checks++;
        if ({ifa.out_data, ifa.out_offset} !== {exp_byte(10'd5, n), 4'(n)}) begin
          errors++; $display("FAIL bp_byte n=%0d got data=%0d off=%0d exp data=%0d off=%0d",
                             n, ifa.out_data, ifa.out_offset, exp_byte(10'd5, n), n);
        end
        n++;
        hold = 1'b0;
      end else if (ifa.out_valid === 1'b1) begin
        hold = 1'b1;
        held = {ifa.out_data, ifa.out_offset, ifa.out_last};
      end else begin
        hold = 1'b0;
      end
      tick;
      cyc++;
    end
    checks++; if (n != 16) begin errors++; $display("FAIL bp_count got=%0d exp=16", n); end
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL bp_extra cyc=%0d got=%b exp=0", i, ifa.out_valid); end
      tick;
    end
  endtask

  task automatic test_multi_wrap;
    int n = 0, cyc = 0, nrd = 0, last_hs = 0;
    logic prev_rd = 1'b0;
    logic [9:0] rd_addr [2];
    rd_addr[0] = 10'd0;
    rd_addr[1] = 10'd0;
    ifa.out_ready = 1'b1;
    ifa.cmd_addr  = 10'd1023;
    ifa.cmd_words = 10'd1;
    ifa.cmd_valid = 1'b1;
    tick;
    ifa.cmd_valid = 1'b0;
    while (n < 32 && cyc < 100) begin
      if (ifa.sram_rd_en === 1'b1) begin
        checks++; if (prev_rd) begin errors++; $display("FAIL wrap_rd_back_to_back cyc=%0d got=1 exp=0", cyc); end
        if (nrd < 2) rd_addr[nrd] = ifa.sram_addr;
        nrd++;
      end
      prev_rd = ifa.sram_rd_en;
      if (ifa.out_valid === 1'b1) begin
        if (n == 16) begin
          checks++; if (cyc - last_hs - 1 != 2) begin errors++; $display("FAIL wrap_bubble got=%0d exp=2", cyc - last_hs - 1); end
        end
        checks++;
        if ({ifa.out_data, ifa.out_last} !== {exp_byte((n < 16) ? 10'd1023 : 10'd0, n % 16), n == 31}) begin
          errors++; $display("FAIL wrap_byte n=%0d got data=%h last=%b exp data=%h last=%b", n, ifa.out_data, ifa.out_last,
                             exp_byte((n < 16) ? 10'd1023 : 10'd0, n % 16), n == 31);
        end
        last_hs = cyc;
        n++;
      end
      tick;
      cyc++;
    end
    checks++; if (n != 32) begin errors++; $display("FAIL wrap_count got=%0d exp=32", n); end
    checks++; if ({nrd[1:0], rd_addr[0], rd_addr[1]} !== {2'd2, 10'd1023, 10'd0}) begin
      errors++; $display("FAIL wrap_reads got n=%0d a0=%0d a1=%0d exp n=2 a0=1023 a1=0", nrd, rd_addr[0], rd_addr[1]); end
    checks++; if (ifa.cmd_ready !== 1'b1) begin errors++; $display("FAIL wrap_done got=%b exp=1", ifa.cmd_ready); end
  endtask

  task automatic test_latency3;
    int n = 0, cyc = 0, rd_cyc = 0;
    ifb.out_ready = 1'b1;
    ifb.cmd_addr  = 10'd9;
    ifb.cmd_words = 10'd1;
    ifb.cmd_valid = 1'b1;
    tick;
    ifb.cmd_valid = 1'b0;
    while (n < 32 && cyc < 100) begin
      if (ifb.sram_rd_en === 1'b1) rd_cyc = cyc;
      if (ifb.out_valid === 1'b1) begin
        if (n % 16 == 0) begin
          checks++; if (cyc - rd_cyc != 4) begin errors++; $display("FAIL lat3_first n=%0d got=%0d exp=4", n, cyc - rd_cyc); end
        end
        checks++;
        if ({ifb.out_data, ifb.out_offset, ifb.out_last} !== {exp_byte((n < 16) ? 10'd9 : 10'd10, n % 16), 4'(n % 16), n == 31}) begin
          errors++; $display("FAIL lat3_byte n=%0d got data=%h off=%0d last=%b exp data=%h", n, ifb.out_data, ifb.out_offset,
                             ifb.out_last, exp_byte((n < 16) ? 10'd9 : 10'd10, n % 16));
        end
        n++;
      end
      tick;
      cyc++;
    end
    checks++; if (n != 32) begin errors++; $display("FAIL lat3_count got=%0d exp=32", n); end
  endtask

  task automatic test_reset_mid;
    int cyc = 0;
    logic found = 1'b0;
    ifa.out_ready = 1'b1;
    ifa.cmd_addr  = 10'd2;
    ifa.cmd_words = 10'd3;
    ifa.cmd_valid = 1'b1;
    tick;
    ifa.cmd_valid = 1'b0;
    while (!found && cyc < 50) begin
      if (ifa.out_valid === 1'b1 && ifa.out_offset === 4'd7) begin
        found = 1'b1;
        rst_n = 1'b1;
      end
      tick;
      cyc++;
    end
    rst_n = 1'b0;
    checks++; if (!found) begin errors++; $display("FAIL rstmid_reach got=0 exp=1"); end
    checks++; if ({ifa.out_valid, ifa.sram_rd_en, ifa.cmd_ready, ifa.busy} !== 4'b0010) begin
      errors++; $display("FAIL rstmid_state got=%b exp=0010", {ifa.out_valid, ifa.sram_rd_en, ifa.cmd_ready, ifa.busy}); end
    for (int i = 0; i < 8; i++) begin
      tick;
      checks++; if ({ifa.out_valid, ifa.sram_rd_en} !== 2'b00) begin
        errors++; $display("FAIL rstmid_quiet cyc=%0d got=%b exp=00", i, {ifa.out_valid, ifa.sram_rd_en}); end
    end
    test_lane_order();
  endtask

  task automatic test_cmd_busy;
    int n = 0, cyc = 0, nrd = 0;
    logic pulsed = 1'b0;
    logic [9:0] rd_addr [2];
    rd_addr[0] = 10'd0;
    rd_addr[1] = 10'd0;
    ifa.out_ready = 1'b1;
    ifa.cmd_addr  = 10'd7;
    ifa.cmd_words = 10'd1;
    ifa.cmd_valid = 1'b1;
    tick;
    while (n < 32 && cyc < 100) begin
      ifa.cmd_valid = 1'b0;
      if (!pulsed && ifa.out_valid === 1'b1 && ifa.out_offset === 4'd3) begin
        pulsed = 1'b1;
        ifa.cmd_addr  = 10'd100;
        ifa.cmd_words = 10'd5;
        ifa.cmd_valid = 1'b1;
        checks++; if (ifa.cmd_ready !== 1'b0) begin errors++; $display("FAIL busy_cmd_ready got=%b exp=0", ifa.cmd_ready); end
      end
      if (ifa.sram_rd_en === 1'b1) begin
        if (nrd < 2) rd_addr[nrd] = ifa.sram_addr;
        nrd++;
      end
      if (ifa.out_valid === 1'b1) begin
        checks++;
        if ({ifa.out_data, ifa.out_last} !== {exp_byte((n < 16) ? 10'd7 : 10'd8, n % 16), n == 31}) begin
          errors++; $display("FAIL busy_byte n=%0d got data=%h last=%b exp data=%h last=%b", n, ifa.out_data, ifa.out_last,
                             exp_byte((n < 16) ? 10'd7 : 10'd8, n % 16), n == 31);
        end
        n++;
      end
      tick;
      cyc++;
    end
    ifa.cmd_valid = 1'b0;
    checks++; if (n != 32) begin errors++; $display("FAIL busy_count got=%0d exp=32", n); end
    checks++; if ({nrd[1:0], rd_addr[0], rd_addr[1]} !== {2'd2, 10'd7, 10'd8}) begin
      errors++; $display("FAIL busy_reads got n=%0d a0=%0d a1=%0d exp n=2 a0=7 a1=8", nrd, rd_addr[0], rd_addr[1]); end
    for (int i = 0; i < 6; i++) begin
      checks++; if ({ifa.cmd_ready, ifa.sram_rd_en, ifa.busy} !== 3'b100) begin
        errors++; $display("FAIL busy_no_queue cyc=%0d got=%b exp=100", i, {ifa.cmd_ready, ifa.sram_rd_en, ifa.busy}); end
      tick;
    end
  endtask

  initial begin
    ifa.cmd_valid = 1'b0; ifa.cmd_addr = 10'd0; ifa.cmd_words = 10'd0; ifa.out_ready = 1'b0;
    ifb.cmd_valid = 1'b0; ifb.cmd_addr = 10'd0; ifb.cmd_words = 10'd0; ifb.out_ready = 1'b1;
    test_reset();
    test_lane_order();
    test_backpressure();
    test_multi_wrap();
    test_latency3();
    test_reset_mid();
    test_cmd_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
